// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg
//   Shared definitions for the counter step scheduler:
//   - cmd_op encodings driven towards the counter datapath
//   - FSM state encoding of the scheduler
//   - repeat timer width
package counter_ctrl_pkg;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ISSUE  = 2'b01,
        ST_DELAY  = 2'b10,
        ST_REPEAT = 2'b11
    } state_t;

    localparam int unsigned TIMER_W = 32;

endpackage

// File: rtl/repeat_timer.sv
// repeat_timer
//   Loadable down-counter that saturates at zero.
//   clk      : clock, rising edge
//   reset    : asynchronous, active-low
//   load     : load load_val this cycle (takes priority over enable)
//   load_val : reload value
//   enable   : decrement by one when non-zero
//   zero     : count is currently zero
module repeat_timer
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/counter_step_scheduler.sv
// counter_step_scheduler
//   Turns held inc/dec buttons into UP/DOWN step commands with an initial
//   repeat delay and a faster auto-repeat period, and forwards load requests
//   as LOAD commands. Commands use a valid/ready handshake.
//   clk       : clock, rising edge
//   reset     : asynchronous, active-low
//   inc, dec  : debounced button levels
//   load_req  : single-cycle pulse, latches load_val and marks a load pending
//   load_val  : value to load
//   cmd_valid : command valid (only while issuing)
//   cmd_op    : NONE / UP / DOWN / LOAD
//   cmd_data  : load value for LOAD, zero otherwise
//   cmd_ready : counter accepts the command this cycle
//   busy      : scheduler is not idle
module counter_step_scheduler
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       load_req,
    input  logic [7:0] load_val,
    output logic       cmd_valid,
    output logic [1:0] cmd_op,
    output logic [7:0] cmd_data,
    input  logic       cmd_ready,
    output logic       busy
);

    localparam logic [TIMER_W-1:0] DELAY_RELOAD  = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] PERIOD_RELOAD = TIMER_W'(REPEAT_PERIOD - 1);

    state_t             state;
    logic               load_pend;
    logic [7:0]         load_latch;
    logic               first;
    logic               dir_up;
    logic               armed;

    logic               timer_load;
    logic               timer_en;
    logic               timer_zero;
    logic [TIMER_W-1:0] timer_val;
    logic               abort;
    logic               load_accept;

    always_comb begin
        load_accept = (state == ST_ISSUE) && cmd_ready && (cmd_op == OP_LOAD);
        timer_load  = (state == ST_ISSUE) && cmd_ready && (cmd_op != OP_LOAD);
        timer_val   = first ? DELAY_RELOAD : PERIOD_RELOAD;
        timer_en    = (state == ST_DELAY) || (state == ST_REPEAT);
        // Both-held must be tested on its own: with the latched button still
        // pressed the release term alone would not fire.
        abort       = (dir_up ? !inc : !dec) || (inc && dec) || load_pend;
    end

    repeat_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .enable   (timer_en),
        .zero     (timer_zero)
    );

    // A fresh pulse wins over the clear so a load arriving while the previous
    // LOAD is being accepted is not lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_pend  <= 1'b0;
            load_latch <= '0;
        end else if (load_req) begin
            load_pend  <= 1'b1;
            load_latch <= load_val;
        end else if (load_accept) begin
            load_pend  <= 1'b0;
        end
    end

    // armed holds off IDLE decisions for the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            first     <= 1'b0;
            dir_up    <= 1'b0;
            armed     <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_op    <= OP_NONE;
            cmd_data  <= '0;
            busy      <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (armed) begin
                        if (load_pend) begin
                            state     <= ST_ISSUE;
                            cmd_valid <= 1'b1;
                            cmd_op    <= OP_LOAD;
                            cmd_data  <= load_latch;
                            busy      <= 1'b1;
                        end else if (inc ^ dec) begin
                            state     <= ST_ISSUE;
                            cmd_valid <= 1'b1;
                            cmd_op    <= inc ? OP_UP : OP_DOWN;
                            cmd_data  <= '0;
                            dir_up    <= inc;
                            first     <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        cmd_op    <= OP_NONE;
                        cmd_data  <= '0;
                        if (cmd_op == OP_LOAD) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= first ? ST_DELAY : ST_REPEAT;
                        end
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (timer_zero) begin
                        state     <= ST_ISSUE;
                        cmd_valid <= 1'b1;
                        cmd_op    <= dir_up ? OP_UP : OP_DOWN;
                        cmd_data  <= '0;
                        first     <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/counter_step_scheduler.md
COUNTER_STEP_SCHEDULER -- requirements
Module: counter_step_scheduler

Interface
REQ-001 Parameter REPEAT_DELAY, default 50000000: cycles from the first accepted step to the first auto-repeat; SHALL be >= 1.
REQ-002 Parameter REPEAT_PERIOD, default 10000000: cycles between auto-repeat steps; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 inc  input  1  debounced level, increment button held.
REQ-006 dec  input  1  debounced level, decrement button held.
REQ-007 load_req  input  1  single-cycle pulse requesting a load of load_val.
REQ-008 load_val  input  8  value to load, sampled when load_req=1.
REQ-009 cmd_valid  output  1  command to the counter datapath is valid.
REQ-010 cmd_op  output  2  00 NONE, 01 UP, 10 DOWN, 11 LOAD.
REQ-011 cmd_data  output  8  load value when cmd_op=LOAD, otherwise 0.
REQ-012 cmd_ready  input  1  the counter accepts the command this cycle.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, DELAY and REPEAT.
REQ-015 A load_req pulse SHALL set load_pend and latch load_val; a new pulse while load_pend=1 SHALL overwrite the latched value.
REQ-016 In IDLE, the block SHALL move to ISSUE as follows: if load_pend=1, with op LOAD; else if exactly one of inc/dec is high, with op UP/DOWN and first=1; inc=dec=1 SHALL cause no action.
REQ-017 In ISSUE, cmd_valid SHALL be 1; cmd_op and cmd_data SHALL stay constant until the cycle in which cmd_ready=1.
REQ-018 On acceptance of a LOAD, the block SHALL clear load_pend and go to IDLE.
REQ-019 On acceptance of UP/DOWN with first=1, the block SHALL go to DELAY with timer=REPEAT_DELAY-1.
REQ-020 On acceptance of UP/DOWN with first=0, the block SHALL go to REPEAT with timer=REPEAT_PERIOD-1.
REQ-021 In DELAY/REPEAT, the timer SHALL decrement each cycle; at timer=0 the block SHALL go to ISSUE with the same direction and first=0.
REQ-022 The block SHALL abort from DELAY/REPEAT to IDLE when: the latched direction's button is released, both buttons are high, or load_pend=1. Abort SHALL take priority over timer expiry.
REQ-023 A button release during ISSUE SHALL NOT withdraw the command; the command SHALL complete and the abort SHALL be evaluated in the following state.
REQ-024 Step spacing with cmd_ready tied high: first step, then a step every REPEAT_DELAY+1 cycles after it for the first repeat, and every REPEAT_PERIOD+1 cycles thereafter.
REQ-025 Outside ISSUE: cmd_valid=0, cmd_op=NONE, cmd_data=0.
REQ-026 Timer width SHALL be 32 bits, unsigned, and SHALL never wrap below 0.

Reset
REQ-027 reset=0 SHALL asynchronously force: state IDLE, timer 0, load_pend 0, latched load value 0, first 0, cmd_valid 0, cmd_op NONE, cmd_data 0, busy 0.
REQ-028 Reset asserted mid-command SHALL drop cmd_valid immediately; no command SHALL be replayed after release.
REQ-029 The first command after reset release SHALL be issued no earlier than the second rising edge.

Structure
REQ-030 Package counter_ctrl_pkg SHALL hold the cmd_op encoding constants and the FSM state encoding.
REQ-031 The down-counter SHALL be a sub-module repeat_timer (inputs: load, load value, enable; output: zero flag).

Verification (REPEAT_DELAY=4, REPEAT_PERIOD=2, cmd_ready=1 unless stated)
REQ-032 Scenario 1: inc pulse high 1 cycle -> exactly one UP command, then IDLE.
REQ-033 Scenario 2: inc held 20 cycles -> UP commands at relative cycles 1, 6, 9, 12, 15, 18; none after release.
REQ-034 Scenario 3: load_req with load_val=0xA5 while dec is held in DELAY -> abort; LOAD with cmd_data=0xA5; then DOWN resumes with first=1.
REQ-035 Scenario 4: cmd_ready=0 for 3 cycles during an UP -> cmd_valid/op held 3 cycles; accepted on the 4th cycle; single command.
REQ-036 Scenario 5: inc and dec high together -> no command issued; busy stays 0.
REQ-037 Scenario 6: reset=0 asserted while cmd_valid=1 -> cmd_valid=0 same cycle; all outputs at reset values.
